// File: rtl/rotor1_fwd_stage.sv
// rtl/rotor1_fwd_stage.sv - rotor 1 forward-path stage: position register, stepping, forward substitution
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_in_valid   one-cycle keypress strobe
//   i_in         input letter, 1..26 = A..Z
//   i_step_in    carry from the previous rotor (only used when STEP_ENABLE=0)
//   i_load_en    load rotor position
//   i_load_pos   position to load, 0..25 (larger values are ignored)
//   o_out        substituted letter 1..26, 0 after an illegal input; holds between strobes
//   o_out_valid  one-cycle strobe, o_out is valid
//   o_err        one-cycle strobe, the input letter was illegal
//   o_pos        current rotor position 0..25; feeds the inverse-path rotate input
//   o_carry_out  one-cycle turnover strobe to the rotor-2 stage

module rotor1_fwd_stage #(
    parameter logic [4:0] NOTCH       = 5'd16,
    parameter logic       STEP_ENABLE = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_in_valid,
    input  logic [4:0] i_in,
    input  logic       i_step_in,
    input  logic       i_load_en,
    input  logic [4:0] i_load_pos,
    output logic [4:0] o_out,
    output logic       o_out_valid,
    output logic       o_err,
    output logic [4:0] o_pos,
    output logic       o_carry_out
);

    logic [4:0] r_pos;
    logic [4:0] r_out;
    logic       r_out_valid;
    logic       r_err;
    logic       r_carry;

    logic [4:0] w_fwd;
    logic       w_legal;
    logic       w_step;
    logic [4:0] w_pos_n;
    logic [5:0] w_sum;
    logic [4:0] w_letter;

    // Rotor-1 forward wiring; illegal letters map to 0 and are never used.
    always_comb begin
        w_fwd = 5'd0;
        case (i_in)
            5'd1:  w_fwd = 5'd16;
            5'd2:  w_fwd = 5'd25;
            5'd3:  w_fwd = 5'd13;
            5'd4:  w_fwd = 5'd4;
            5'd5:  w_fwd = 5'd17;
            5'd6:  w_fwd = 5'd7;
            5'd7:  w_fwd = 5'd14;
            5'd8:  w_fwd = 5'd3;
            5'd9:  w_fwd = 5'd8;
            5'd10: w_fwd = 5'd19;
            5'd11: w_fwd = 5'd22;
            5'd12: w_fwd = 5'd11;
            5'd13: w_fwd = 5'd23;
            5'd14: w_fwd = 5'd18;
            5'd15: w_fwd = 5'd1;
            5'd16: w_fwd = 5'd15;
            5'd17: w_fwd = 5'd6;
            5'd18: w_fwd = 5'd24;
            5'd19: w_fwd = 5'd21;
            5'd20: w_fwd = 5'd9;
            5'd21: w_fwd = 5'd10;
            5'd22: w_fwd = 5'd20;
            5'd23: w_fwd = 5'd5;
            5'd24: w_fwd = 5'd2;
            5'd25: w_fwd = 5'd26;
            5'd26: w_fwd = 5'd12;
            default: w_fwd = 5'd0;
        endcase
    end

    assign w_legal = (i_in >= 5'd1) && (i_in <= 5'd26);
    assign w_step  = i_in_valid && w_legal && (STEP_ENABLE || i_step_in);

    // The rotor steps before the letter passes through it.
    assign w_pos_n = w_step ? ((r_pos == 5'd25) ? 5'd0 : r_pos + 5'd1) : r_pos;

    // Sum is at most 26+25=51, so a single conditional subtract reduces it
    // to 1..26; a residue of 0 naturally appears as 26.
    assign w_sum    = {1'b0, w_fwd} + {1'b0, w_pos_n};
    assign w_letter = (w_sum > 6'd26) ? 5'(w_sum - 6'd26) : w_sum[4:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos       <= 5'd0;
            r_out       <= 5'd0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_carry     <= 1'b0;
            if (i_load_en) begin
                // A load swallows any keypress in the same cycle.
                if (i_load_pos <= 5'd25) begin
                    r_pos <= i_load_pos;
                end
            end else if (i_in_valid) begin
                r_out_valid <= 1'b1;
                if (w_legal) begin
                    r_pos   <= w_pos_n;
                    r_out   <= w_letter;
                    r_carry <= w_step && (r_pos == NOTCH);
                end else begin
                    r_err <= 1'b1;
                    r_out <= 5'd0;
                end
            end
        end
    end

    assign o_pos       = r_pos;
    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_err       = r_err;
    assign o_carry_out = r_carry;

endmodule

// File: tb/tb_rotor1_fwd_stage.sv
// tb/tb_rotor1_fwd_stage.sv - self-checking bench for rotor1_fwd_stage (both stepping modes)

module tb_rotor1_fwd_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [4:0] in_l;
    logic       step_in;
    logic       load_en;
    logic [4:0] load_pos;

    logic [4:0] out_a, pos_a, out_b, pos_b;
    logic       ov_a, err_a, cy_a, ov_b, err_b, cy_b;

    int total = 0;
    int bad   = 0;

    // Reference state: index 0 = STEP_ENABLE=1 instance, 1 = STEP_ENABLE=0 instance.
    int m_pos[2];
    int m_out[2];
    int m_ov[2];
    int m_err[2];
    int m_cy[2];

    int fwd[26] = '{16,25,13,4,17,7,14,3,8,19,22,11,23,18,1,15,6,24,21,9,10,20,5,2,26,12};

    always #5 clk = ~clk;

    rotor1_fwd_stage #(.NOTCH(5'd16), .STEP_ENABLE(1'b1)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .i_in(in_l),
        .i_step_in(step_in), .i_load_en(load_en), .i_load_pos(load_pos),
        .o_out(out_a), .o_out_valid(ov_a), .o_err(err_a), .o_pos(pos_a), .o_carry_out(cy_a)
    );

    rotor1_fwd_stage #(.NOTCH(5'd16), .STEP_ENABLE(1'b0)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .i_in(in_l),
        .i_step_in(step_in), .i_load_en(load_en), .i_load_pos(load_pos),
        .o_out(out_b), .o_out_valid(ov_b), .o_err(err_b), .o_pos(pos_b), .o_carry_out(cy_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the reference by one clock from the current inputs.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_ov[k] = 0; m_err[k] = 0; m_cy[k] = 0;
            if (reset) begin
                m_pos[k] = 0; m_out[k] = 0;
            end else if (load_en) begin
                if (load_pos <= 25) m_pos[k] = load_pos;
            end else if (in_valid) begin
                m_ov[k] = 1;
                if (in_l >= 1 && in_l <= 26) begin
                    if (k == 0 || step_in) begin
                        m_cy[k]  = (m_pos[k] == 16) ? 1 : 0;
                        m_pos[k] = (m_pos[k] + 1) % 26;
                    end
                    m_out[k] = (fwd[in_l - 1] + m_pos[k] - 1) % 26 + 1;
                end else begin
                    m_err[k] = 1;
                    m_out[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("a.pos", pos_a, 8'(m_pos[0]));
        chk("a.out", out_a, 8'(m_out[0]));
        chk("a.out_valid", ov_a, 8'(m_ov[0]));
        chk("a.err", err_a, 8'(m_err[0]));
        chk("a.carry", cy_a, 8'(m_cy[0]));
        chk("b.pos", pos_b, 8'(m_pos[1]));
        chk("b.out", out_b, 8'(m_out[1]));
        chk("b.out_valid", ov_b, 8'(m_ov[1]));
        chk("b.err", err_b, 8'(m_err[1]));
        chk("b.carry", cy_b, 8'(m_cy[1]));
    endtask

    // Apply one cycle of inputs, check the outputs one cycle later, then go idle.
    task automatic cyc(input logic rst, input logic ld, input int lp,
                       input logic v, input int letter, input logic st);
        reset = rst; load_en = ld; load_pos = 5'(lp);
        in_valid = v; in_l = 5'(letter); step_in = st;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0; load_en = 1'b0; in_valid = 1'b0; step_in = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_l = 5'd0; step_in = 1'b0;
        load_en = 1'b0; load_pos = 5'd0;
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = 0; m_out[k] = 0; m_ov[k] = 0; m_err[k] = 0; m_cy[k] = 0;
        end

        // Reset then idle.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("idle.pos", pos_a, 8'd0);

        // Two presses of A from position 0.
        cyc(0, 0, 0, 1, 1, 0);
        chk("press1.out", out_a, 8'd17);
        chk("press1.pos", pos_a, 8'd1);
        cyc(0, 0, 0, 1, 1, 0);
        chk("press2.out", out_a, 8'd18);
        cyc(0, 0, 0, 0, 0, 0);
        chk("strobe.single", ov_a, 8'd0);

        // Residue zero and wrap.
        cyc(0, 1, 9, 0, 0, 0);
        cyc(0, 0, 0, 1, 25, 0);
        chk("res0.out", out_a, 8'd10);
        cyc(0, 1, 25, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 0);
        chk("wrap.out", out_a, 8'd25);
        chk("wrap.pos", pos_a, 8'd0);

        // Turnover at the notch, then no carry on the next press.
        cyc(0, 1, 16, 0, 0, 1);
        cyc(0, 0, 0, 1, 4, 1);
        chk("turn.out", out_a, 8'd21);
        chk("turn.carry", cy_a, 8'd1);
        cyc(0, 0, 0, 1, 4, 0);
        chk("turn.next_carry", cy_a, 8'd0);

        // Illegal letters.
        cyc(0, 1, 5, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        chk("ill0.err", err_a, 8'd1);
        cyc(0, 0, 0, 1, 27, 1);
        chk("ill27.pos", pos_a, 8'd5);
        cyc(0, 0, 0, 1, 31, 0);

        // Load priority and out-of-range load.
        cyc(0, 1, 3, 1, 7, 1);
        chk("ldpri.pos", pos_a, 8'd3);
        chk("ldpri.valid", ov_a, 8'd0);
        cyc(0, 1, 30, 0, 0, 0);
        chk("ld30.pos", pos_a, 8'd3);

        // Reset with a keypress.
        cyc(0, 0, 0, 1, 10, 1);
        cyc(1, 0, 0, 1, 10, 1);
        chk("rstpress.valid", ov_a, 8'd0);
        chk("rstpress.pos", pos_a, 8'd0);

        // Stepping through the carry input on the gated instance.
        cyc(0, 1, 16, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 0);
        chk("gated.nostep.pos", pos_b, 8'd16);
        cyc(0, 0, 0, 1, 3, 1);
        chk("gated.step.pos", pos_b, 8'd17);
        chk("gated.step.carry", cy_b, 8'd1);

        // Randomized traffic, including back-to-back presses and notch crossings.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            cyc((r == 0) ? 1'b1 : 1'b0,
                (r >= 1 && r < 6) ? 1'b1 : 1'b0,
                $urandom_range(0, 31),
                (r >= 10 && r < 85) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 26),
                1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rotor1_fwd_stage.md
Name: rotor1_fwd_stage

Overview:
Forward-path stage of rotor 1. It carries the keyboard-to-reflector signal and is the counterpart of the rotor-1 inverse path.
- Holds the rotor position register and steps it on each keypress.
- Applies the rotor-1 forward substitution at the stepped position and registers the result with a valid strobe.
- Drives the position to the inverse-path stage and a turnover carry to the rotor-2 stage.

Parameters:
NOTCH, 5'd16, position value (0..25) from which a step produces a turnover carry.
STEP_ENABLE, 1'b1, 1 = rotor steps on every valid keypress; 0 = steps only when step_in=1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  one-cycle keypress strobe
in  input  5  letter, 1..26 = A..Z
step_in  input  1  carry from the previous rotor; used only when STEP_ENABLE=0
load_en  input  1  load rotor position
load_pos  input  5  position to load, 0..25
out  output  5  substituted letter, 1..26
out_valid  output  1  one-cycle strobe, out is valid
err  output  1  one-cycle strobe, the input letter was illegal
pos  output  5  current rotor position, 0..25; feeds the inverse-path rotate input
carry_out  output  1  one-cycle turnover strobe to the next rotor

Behaviour:
- Reset is synchronous, active-high, and sampled on the clk rising edge. It overrides all other inputs.
  - Reset values: pos=0, out=0, out_valid=0, err=0, carry_out=0.
  - Reset asserted mid-operation discards any pending result; no strobe occurs in the following cycle.
- Forward table F(1..26) = 16,25,13,4,17,7,14,3,8,19,22,11,23,18,1,15,6,24,21,9,10,20,5,2,26,12.
  - The inverse stage implements exactly F^-1 at the same position.
- Step decision: step = in_valid & legal & (STEP_ENABLE | step_in).
  - legal = (in >= 1) & (in <= 26).
- Next position: pos_n = step ? (pos==25 ? 0 : pos+1) : pos. Wrap is 25 -> 0.
- Substitution uses the post-step position, i.e. Enigma steps before encryption.
  - out = ((F(in) + pos_n) mod 26), with residue 0 encoded as 26.
  - Compute the sum in 6 bits; maximum value is 26+25=51, so no overflow.
- Latency: 1 cycle. A keypress in cycle N gives out/out_valid/pos/carry_out in cycle N+1.
  - pos in N+1 equals the position used for out.
  - The inverse path samples pos in the same cycle the reflected letter returns.
- Back-to-back keypresses, one per cycle, are supported; each produces its own strobe and step.
- Output hold: out holds its last value between strobes. out_valid, err and carry_out are single-cycle pulses.
- Illegal letter (in = 0 or 27..31) with in_valid=1:
  - No step; err=1 and out_valid=1 in N+1; out=0.
- carry_out=1 in N+1 exactly when step=1 and pos (pre-step) == NOTCH.
  - No carry on load. No carry on an illegal input.
- Load:
  - load_en=1 with load_pos <= 25: pos <= load_pos next cycle.
  - load_pos >= 26: ignored; pos unchanged.
  - load_en has priority over in_valid in the same cycle: the keypress is dropped, with no strobe and no step.
- pos changes only via reset, load, or step.

Test Plan:
- Reset, then idle 3 cycles -> pos=0, out=0, out_valid=0, err=0, carry_out=0 throughout.
- STEP_ENABLE=1, pos=0, in_valid with in=1 -> next cycle pos=1, out=17, out_valid=1 for exactly one cycle; a second press of in=1 -> pos=2, out=18.
- Residue-zero case: load 9, press in=25 -> pos=10, out=10. Wrap case: load 25, press in=2 -> pos=0, out=25, carry_out=0.
- Turnover: load 16, press in=4 -> pos=17, out=21 (4+17), carry_out=1 for one cycle; the next press gives carry_out=0.
- Illegal input in=0 and in=27 at pos=5 -> err=1, out_valid=1, out=0, pos stays 5, carry_out=0.
- load_en=1 (load_pos=3) together with in_valid -> pos=3, no out_valid. load_pos=30 -> pos unchanged.
- Reset asserted in the same cycle as in_valid -> no strobe in the next cycle, pos=0.
- STEP_ENABLE=0: press with step_in=0 -> pos unchanged and out = F(in)+pos; press with step_in=1 -> pos advances.
